// File: rtl/flow_ctrl_unit.sv
// flow_ctrl_unit: fetch/decode flow control with hazard bubbles, PC redirect and bubble statistics
module flow_ctrl_unit #(
   parameter int          LW_STALL = 1,
   parameter int          JR_DELAY = 2,
   parameter logic [31:0] NOP_CMD  = 32'h00000020,
   parameter int          STAT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       cmd_i,
   input  logic              cmd_valid_i,
   input  logic              br_resolve_i,
   input  logic              br_taken_i,
   output logic [31:0]       cmd_o,
   output logic              cmd_valid_o,
   output logic              stall_o,
   output logic              redirect_o,
   output logic [1:0]        pc_sel_o,
   output logic [15:0]       imm_o,
   output logic [25:0]       jmp_addr_o,
   output logic [STAT_W-1:0] bubble_cnt_o
);
   localparam int MAXD = (LW_STALL > JR_DELAY) ? LW_STALL : JR_DELAY;
   localparam int CW = $clog2(MAXD + 1);
   localparam logic [2:0] RUN = 3'd0, LW_WAIT = 3'd1, JR_WAIT = 3'd2, BR_WAIT = 3'd3, FLUSH = 3'd4;
   logic [2:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic [31:0]       r_cmd;
   logic              r_valid;
   logic              r_redirect;
   logic [1:0]        r_pc_sel;
   logic [15:0]       r_imm;
   logic [25:0]       r_jmp;
   logic [STAT_W-1:0] r_bubble;
   logic [5:0]        w_op;
   logic              w_is_lw, w_is_j, w_is_jr, w_is_br, w_last;
   assign w_op    = cmd_i[31:26];
   assign w_is_lw = w_op == 6'h23;
   assign w_is_j  = w_op == 6'h02 || w_op == 6'h03;
   assign w_is_jr = w_op == 6'h00 && cmd_i[5:0] == 6'h08;
   assign w_is_br = w_op == 6'h04 || w_op == 6'h05;
   assign w_last  = r_cnt <= CW'(1);
   assign stall_o      = r_state != RUN;
   assign cmd_o        = r_cmd;
   assign cmd_valid_o  = r_valid;
   assign redirect_o   = r_redirect;
   assign pc_sel_o     = r_pc_sel;
   assign imm_o        = r_imm;
   assign jmp_addr_o   = r_jmp;
   assign bubble_cnt_o = r_bubble;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= RUN;
         r_cnt      <= '0;
         r_cmd      <= NOP_CMD;
         r_valid    <= 1'b0;
         r_redirect <= 1'b0;
         r_pc_sel   <= 2'b00;
         r_imm      <= '0;
         r_jmp      <= '0;
         r_bubble   <= '0;
      end else begin
         r_redirect <= 1'b0;
         r_pc_sel   <= 2'b00;
         if (r_state == RUN) begin
            r_cmd   <= cmd_valid_i ? cmd_i : NOP_CMD;
            r_valid <= cmd_valid_i;
            if (cmd_valid_i) begin
               r_imm <= cmd_i[15:0];
               r_jmp <= cmd_i[25:0];
               if (w_is_lw) begin
                  r_state <= LW_WAIT;
                  r_cnt   <= CW'(LW_STALL);
               end else if (w_is_jr) begin
                  r_state <= JR_WAIT;
                  r_cnt   <= CW'(JR_DELAY);
               end else if (w_is_br) begin
                  r_state <= BR_WAIT;
               end else if (w_is_j) begin
                  r_state    <= FLUSH;
                  r_redirect <= 1'b1;
                  r_pc_sel   <= 2'b01;
               end
            end
         end else begin
            // every non-RUN cycle emits exactly one counted bubble
            r_cmd   <= NOP_CMD;
            r_valid <= 1'b0;
            if (~&r_bubble) r_bubble <= r_bubble + 1'b1;
            if (r_state == LW_WAIT) begin
               r_cnt   <= r_cnt - CW'(1);
               r_state <= w_last ? RUN : LW_WAIT;
            end else if (r_state == JR_WAIT) begin
               r_cnt      <= r_cnt - CW'(1);
               r_state    <= w_last ? FLUSH : JR_WAIT;
               r_redirect <= w_last;
               r_pc_sel   <= w_last ? 2'b10 : 2'b00;
            end else if (r_state == BR_WAIT) begin
               if (br_resolve_i) begin
                  r_state    <= br_taken_i ? FLUSH : RUN;
                  r_redirect <= br_taken_i;
                  r_pc_sel   <= br_taken_i ? 2'b11 : 2'b00;
               end
            end else begin
               r_state <= RUN;
            end
         end
      end
   end
endmodule

// File: tb/tb_flow_ctrl_unit.sv
// tb_flow_ctrl_unit: directed checks of hazard bubbles, redirects, reset and bubble counter saturation
module tb_flow_ctrl_unit;
   localparam logic [31:0] NOP = 32'h00000020;
   localparam logic [31:0] LW  = 32'h8C080000;
   localparam logic [31:0] ADD = 32'h01094020;
   localparam logic [31:0] J   = 32'h08000010;
   localparam logic [31:0] JR  = 32'h03E00008;
   localparam logic [31:0] BEQ = 32'h11090004;
   localparam logic [31:0] BNE = 32'h15090004;
   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] cmd_i = '0;
   logic        cmd_valid_i = 1'b0, br_resolve_i = 1'b0, br_taken_i = 1'b0;
   logic [31:0] cmd_o, s_cmd_o;
   logic        cmd_valid_o, stall_o, redirect_o, s_valid, s_stall, s_redirect;
   logic [1:0]  pc_sel_o, s_pc_sel;
   logic [15:0] imm_o, s_imm;
   logic [25:0] jmp_addr_o, s_jmp;
   logic [15:0] bubble_cnt_o;
   logic [1:0]  s_bubble;
   int n_tests = 0, n_fail = 0;
   flow_ctrl_unit dut (
      .clk(clk), .reset(reset), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
      .br_resolve_i(br_resolve_i), .br_taken_i(br_taken_i), .cmd_o(cmd_o),
      .cmd_valid_o(cmd_valid_o), .stall_o(stall_o), .redirect_o(redirect_o),
      .pc_sel_o(pc_sel_o), .imm_o(imm_o), .jmp_addr_o(jmp_addr_o), .bubble_cnt_o(bubble_cnt_o)
   );
   flow_ctrl_unit #(.STAT_W(2)) sat (
      .clk(clk), .reset(reset), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
      .br_resolve_i(br_resolve_i), .br_taken_i(br_taken_i), .cmd_o(s_cmd_o),
      .cmd_valid_o(s_valid), .stall_o(s_stall), .redirect_o(s_redirect),
      .pc_sel_o(s_pc_sel), .imm_o(s_imm), .jmp_addr_o(s_jmp), .bubble_cnt_o(s_bubble)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic [31:0] c, input logic v, input logic s,
                          input logic r, input logic [1:0] p, input logic [15:0] b);
      chk({tag, ".cmd"}, cmd_o, c);
      chk({tag, ".valid"}, 32'(cmd_valid_o), 32'(v));
      chk({tag, ".stall"}, 32'(stall_o), 32'(s));
      chk({tag, ".redir"}, 32'(redirect_o), 32'(r));
      chk({tag, ".pcsel"}, 32'(pc_sel_o), 32'(p));
      chk({tag, ".bub"}, 32'(bubble_cnt_o), 32'(b));
   endtask
   initial begin
      step();
      step();
      chk_out("rst", NOP, 0, 0, 0, 2'b00, 0);
      chk("rst.imm", 32'(imm_o), 0);
      chk("rst.jmp", 32'(jmp_addr_o), 0);
      chk("rst.sat", 32'(s_bubble), 0);
      reset = 1'b0;
      step();
      chk_out("idle", NOP, 0, 0, 0, 2'b00, 0);
      cmd_i = LW; cmd_valid_i = 1'b1;
      step();
      chk_out("lw.acc", LW, 1, 1, 0, 2'b00, 0);
      cmd_i = ADD;
      step();
      chk_out("lw.bub", NOP, 0, 0, 0, 2'b00, 1);
      chk("lw.sat", 32'(s_bubble), 1);
      step();
      chk_out("lw.use", ADD, 1, 0, 0, 2'b00, 1);
      chk("add.imm", 32'(imm_o), 32'h4020);
      cmd_i = J;
      step();
      chk_out("j.acc", J, 1, 1, 1, 2'b01, 1);
      chk("j.jmp", 32'(jmp_addr_o), 32'h10);
      cmd_i = ADD;
      step();
      chk_out("j.flush", NOP, 0, 0, 0, 2'b00, 2);
      cmd_valid_i = 1'b0;
      step();
      chk_out("j.idle", NOP, 0, 0, 0, 2'b00, 2);
      cmd_i = JR; cmd_valid_i = 1'b1;
      step();
      chk_out("jr.acc", JR, 1, 1, 0, 2'b00, 2);
      cmd_i = ADD;
      step();
      chk_out("jr.w1", NOP, 0, 1, 0, 2'b00, 3);
      step();
      chk_out("jr.w2", NOP, 0, 1, 1, 2'b10, 4);
      step();
      chk_out("jr.flush", NOP, 0, 0, 0, 2'b00, 5);
      chk("jr.sat", 32'(s_bubble), 3);
      cmd_i = BEQ;
      step();
      chk_out("beq.acc", BEQ, 1, 1, 0, 2'b00, 5);
      cmd_i = ADD;
      step();
      chk_out("beq.w1", NOP, 0, 1, 0, 2'b00, 6);
      step();
      chk_out("beq.w2", NOP, 0, 1, 0, 2'b00, 7);
      br_resolve_i = 1'b1; br_taken_i = 1'b1;
      step();
      chk_out("beq.tk", NOP, 0, 1, 1, 2'b11, 8);
      br_resolve_i = 1'b0; br_taken_i = 1'b0;
      step();
      chk_out("beq.flush", NOP, 0, 0, 0, 2'b00, 9);
      chk("beq.sat", 32'(s_bubble), 3);
      cmd_i = BNE;
      step();
      chk_out("bne.acc", BNE, 1, 1, 0, 2'b00, 9);
      cmd_i = ADD;
      step();
      step();
      br_resolve_i = 1'b1;
      step();
      chk_out("bne.nt", NOP, 0, 0, 0, 2'b00, 12);
      br_resolve_i = 1'b0;
      step();
      chk_out("bne.fall", ADD, 1, 0, 0, 2'b00, 12);
      br_resolve_i = 1'b1; br_taken_i = 1'b1;
      step();
      chk_out("run.res", ADD, 1, 0, 0, 2'b00, 12);
      br_resolve_i = 1'b0; br_taken_i = 1'b0;
      cmd_i = JR;
      step();
      cmd_i = ADD;
      step();
      chk_out("jr2.w1", NOP, 0, 1, 0, 2'b00, 13);
      #2 reset = 1'b1;
      step();
      chk_out("rst.mid", NOP, 0, 0, 0, 2'b00, 0);
      chk("rst.mid.sat", 32'(s_bubble), 0);
      reset = 1'b0; cmd_valid_i = 1'b0;
      step();
      chk_out("rst.after", NOP, 0, 0, 0, 2'b00, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
